// File: rtl/rca_blockserial_add_pkg.sv
// Shared types and constants for the block-serial ripple-carry adder.
//   state_e   : controller states (IDLE / RUN / DONE)
//   DEF_WIDTH : default operand width
//   DEF_BLK   : default slice width
//   cnt_width : width of the block counter for a given block count (min 1)
package rca_blockserial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 80;
  localparam int DEF_BLK   = 16;

  // A single-block adder still needs a 1-bit counter to keep the RTL uniform.
  function automatic int cnt_width(input int nblk);
    return (nblk <= 1) ? 1 : $clog2(nblk);
  endfunction

endpackage

// File: rtl/rca_blockserial_add_if.sv
// Operand/result bus of the block-serial adder.
//   in_valid/in_ready   : operand handshake (A, B, Cin)
//   out_valid/out_ready : result handshake (S, Cout, ovf)
//   busy                : adder is stepping through blocks
//   dbg_state           : controller state, for observation only
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. A source holding valid keeps its data
// stable until that edge; ready may depend combinationally on the other side.
interface rca_blockserial_add_if #(
  parameter int WIDTH = rca_blockserial_add_pkg::DEF_WIDTH
);
  import rca_blockserial_add_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;
  logic             busy;
  state_e           dbg_state;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, S, Cout, ovf, busy, dbg_state
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, S, Cout, ovf, busy, dbg_state
  );

endinterface

// File: rtl/rca_blockserial_add_block.sv
// Combinational BLK-bit ripple-carry slice.
//   a, b     : slice operands
//   cin      : carry into bit 0 of the slice
//   s        : slice sum
//   cout     : carry out of the slice MSB
//   c_msb_in : carry into the slice MSB (used for signed overflow)
module rca_blockserial_add_block #(
  parameter int BLK = 16
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  logic [BLK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < BLK; i++) begin : g_bit
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign s        = a ^ b ^ c[BLK-1:0];
  assign cout     = c[BLK];
  assign c_msb_in = c[BLK-1];

endmodule

// File: rtl/rca_blockserial_add.sv
// Block-serial ripple-carry adder: one BLK-bit slice per clock, carry kept in
// a flop between slices, NBLK = WIDTH/BLK run cycles per operation.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the operand/result bus (see rca_blockserial_add_if)
// Result S/Cout/ovf is held stable in DONE until out_ready; in DONE a new
// operand set can be accepted on the same edge that the result is taken.
module rca_blockserial_add
  import rca_blockserial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK   = DEF_BLK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca_blockserial_add_if.slave bus
);

  localparam int NBLK  = (BLK < 1) ? 1 : WIDTH / BLK;
  localparam int CNT_W = cnt_width(NBLK);

  if (BLK < 1) begin : g_bad_blk
    $error("rca_blockserial_add: BLK must be >= 1");
  end else if ((WIDTH % BLK) != 0) begin : g_bad_width
    $error("rca_blockserial_add: WIDTH must be a multiple of BLK");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic               in_ready;
  logic [31:0]        blk_base;
  logic [BLK-1:0]     blk_a;
  logic [BLK-1:0]     blk_b;
  logic [BLK-1:0]     blk_s;
  logic               blk_cout;
  logic               blk_c_msb;

  // Operands are taken in IDLE, or in DONE when the result leaves this edge.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);

  // Single shared slice: the counter selects which block feeds it.
  assign blk_base = 32'(cnt_q) * 32'(BLK);
  assign blk_a    = a_q[blk_base +: BLK];
  assign blk_b    = b_q[blk_base +: BLK];

  rca_blockserial_add_block #(.BLK(BLK)) u_block (
    .a        (blk_a),
    .b        (blk_b),
    .cin      (carry_q),
    .s        (blk_s),
    .cout     (blk_cout),
    .c_msb_in (blk_c_msb)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.Cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        s_d[blk_base +: BLK] = blk_s;
        carry_d              = blk_cout;
        cnt_d                = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NBLK - 1)) begin
          // Last slice holds the word MSB, so its carries give Cout and ovf.
          cout_d      = blk_cout;
          ovf_d       = blk_c_msb ^ blk_cout;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (bus.in_valid) begin
            a_d     = bus.A;
            b_d     = bus.B;
            carry_d = bus.Cin;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rca_blockserial_add.sv
// Directed bench for rca_blockserial_add (WIDTH=80, BLK=16, NBLK=5).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rca_blockserial_add;
  import rca_blockserial_add_pkg::*;

  localparam int WIDTH = 80;
  localparam int BLK   = 16;
  localparam int LAT   = 6;   // falling-edge samples from accept to out_valid

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rca_blockserial_add_if #(.WIDTH(WIDTH)) bus ();

  rca_blockserial_add #(.WIDTH(WIDTH), .BLK(BLK)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk_vec(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present operands for one cycle, then scramble them to prove capture.
  task automatic send(input string tag, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic cin);
    @(negedge clk);
    chk_bit({tag, "_in_ready"}, bus.in_ready, 1'b1);
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = {16'($urandom), $urandom, $urandom};
    bus.B        = {16'($urandom), $urandom, $urandom};
    bus.Cin      = 1'($urandom_range(0, 1));
  endtask

  // Count falling edges until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin,
                        input logic [WIDTH-1:0] exp_s, input logic exp_cout,
                        input logic exp_ovf, input int hold);
    int n;
    logic [WIDTH-1:0] exp;
    exp_q.push_back(exp_s);
    send(tag, a, b, cin);
    wait_valid(n);
    exp = exp_q.pop_front();
    chk_int({tag, "_latency"}, n, LAT);
    chk_vec({tag, "_S"}, bus.S, exp);
    chk_bit({tag, "_Cout"}, bus.Cout, exp_cout);
    chk_bit({tag, "_ovf"}, bus.ovf, exp_ovf);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk_vec({tag, "_hold_S"}, bus.S, exp);
      chk_bit({tag, "_hold_valid"}, bus.out_valid, 1'b1);
      chk_bit({tag, "_hold_in_ready"}, bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk_bit({tag, "_popped"}, bus.out_valid, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int m;
    logic [WIDTH-1:0] exp;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #20;
    chk_bit("rst_out_valid", bus.out_valid, 1'b0);
    chk_vec("rst_S", bus.S, '0);
    chk_bit("rst_Cout", bus.Cout, 1'b0);
    chk_bit("rst_ovf", bus.ovf, 1'b0);
    chk_bit("rst_busy", bus.busy, 1'b0);
    chk_bit("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) 1 + 1
    run_op("t1", 80'h1, 80'h1, 1'b0, 80'h2, 1'b0, 1'b0, 0);

    // 2) carry ripples through blocks 0..2
    run_op("t2", 80'h0000FFFFFFFFFFFF, 80'h1, 1'b0,
           80'h0001000000000000, 1'b0, 1'b0, 0);

    // 3) all ones + carry-in wraps to zero; carry-in alone
    run_op("t3a", {WIDTH{1'b1}}, 80'h0, 1'b1, 80'h0, 1'b1, 1'b0, 0);
    run_op("t3b", 80'h0, 80'h0, 1'b1, 80'h1, 1'b0, 1'b0, 0);

    // 4) mixed pattern; digit-by-digit: ...1234567890FFFF + ...1111 + 1
    //    gives ...23456789A21111 in the low 14 digits
    run_op("t4", 80'hABCDEF1234567890FFFF, 80'h11111111111111111111, 1'b1,
           80'hBCDF0023456789A21111, 1'b0, 1'b0, 0);

    // 5) positive overflow, then 10 cycles of backpressure
    run_op("t5", {1'b0, {(WIDTH-1){1'b1}}}, 80'h1, 1'b0,
           {1'b1, {(WIDTH-1){1'b0}}}, 1'b0, 1'b1, 10);

    // 6) back-to-back with in_valid and out_ready held high
    exp_q.push_back(80'd12);
    exp_q.push_back(80'd301);
    @(negedge clk);
    bus.A         = 80'd5;
    bus.B         = 80'd7;
    bus.Cin       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.A   = 80'd100;
    bus.B   = 80'd200;
    bus.Cin = 1'b1;
    wait_valid(n);
    exp = exp_q.pop_front();
    chk_int("b2b_first_latency", n, LAT);
    chk_vec("b2b_first_S", bus.S, exp);
    wait_valid(m);
    exp = exp_q.pop_front();
    chk_int("b2b_spacing", m, LAT);
    chk_vec("b2b_second_S", bus.S, exp);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk_bit("b2b_done_valid", bus.out_valid, 1'b0);
    chk_bit("b2b_idle_ready", bus.in_ready, 1'b1);

    // Reset in the middle of RUN
    send("rst_mid", 80'h1234, 80'h1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_bit("rst_mid_busy", bus.busy, 1'b1);
    chk_vec("rst_mid_partial_S", bus.S, 80'h1235);
    #1 rst_n = 1'b0;
    #1;
    chk_bit("rst_mid_out_valid", bus.out_valid, 1'b0);
    chk_vec("rst_mid_S", bus.S, '0);
    chk_bit("rst_mid_busy_low", bus.busy, 1'b0);
    chk_bit("rst_mid_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 80'd3, 80'd4, 1'b0, 80'd7, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
